// File: rtl/seq_bcd_outport_if.sv
// Bus between a CPU output port and the seven-segment driver.
// Ports: data_in (port value, toward driver); hex_hi/hex_lo (active-low
// segments {g,f,e,d,c,b,a}); busy (conversion running); done (one-cycle update pulse).
interface seq_bcd_outport_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_in;
  logic [6:0]       hex_hi;
  logic [6:0]       hex_lo;
  logic             busy;
  logic             done;

  // master: the side that owns data_in (CPU port / testbench)
  modport master (output data_in, input hex_hi, hex_lo, busy, done);
  // slave: the display driver
  modport slave  (input data_in, output hex_hi, hex_lo, busy, done);
endinterface

// File: rtl/seq_bcd_outport.sv
// Sequential two-digit decimal display driver for one CPU output port.
// A change on data_in is latched, converted by a 7-step shift-add-3 engine,
// and shown on hex_hi/hex_lo. Values above 99 show dash/dash.
// Ports: clock, reset (async, active-high), port (slave side of seq_bcd_outport_if).
module seq_bcd_outport #(
  parameter int WIDTH              = 32,
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input logic               clock,
  input logic               reset,
  seq_bcd_outport_if.slave  port
);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] HI_RESET  = BLANK_LEADING_ZERO ? SEG_BLANK : SEG_ZERO;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  state_t           state_q;
  logic [WIDTH-1:0] last_q;
  logic [6:0]       sr_q;
  logic [7:0]       bcd_q;
  logic [2:0]       cnt_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;
  logic [6:0]       hex_hi_q;
  logic [6:0]       hex_lo_q;

  // BCD digits after the add-3 correction, ready to be shifted.
  logic [7:0] bcd_d;

  always_comb begin
    bcd_d = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_d[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_d[7:4] = bcd_q[7:4] + 4'd3;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= '0;
      sr_q     <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hex_hi_q <= HI_RESET;
      hex_lo_q <= SEG_ZERO;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (port.data_in != last_q) begin
            last_q <= port.data_in;
            // Only the low 7 bits are converted; anything wider than 99
            // takes the overflow path and never reaches the shifter.
            sr_q   <= port.data_in[6:0];
            busy_q <= 1'b1;
            if (port.data_in > WIDTH'(99)) begin
              ovf_q   <= 1'b1;
              state_q <= UPDATE;
            end else begin
              bcd_q   <= '0;
              cnt_q   <= '0;
              state_q <= SHIFT;
            end
          end
        end

        SHIFT: begin
          // Shift the corrected {bcd, sr} pair left by one bit.
          {bcd_q, sr_q} <= {bcd_d[6:0], sr_q, 1'b0};
          cnt_q         <= cnt_q + 3'd1;
          if (cnt_q == 3'd6) state_q <= UPDATE;
        end

        UPDATE: begin
          if (ovf_q) begin
            hex_hi_q <= SEG_DASH;
            hex_lo_q <= SEG_DASH;
          end else begin
            hex_lo_q <= seg_code(bcd_q[3:0]);
            if (BLANK_LEADING_ZERO && (bcd_q[7:4] == 4'd0))
              hex_hi_q <= SEG_BLANK;
            else
              hex_hi_q <= seg_code(bcd_q[7:4]);
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          ovf_q   <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign port.hex_hi = hex_hi_q;
  assign port.hex_lo = hex_lo_q;
  assign port.busy   = busy_q;
  assign port.done   = done_q;

endmodule

// File: tb/tb_seq_bcd_outport.sv
// Self-checking bench for seq_bcd_outport: two instances (leading-zero blanking
// on and off) driven in lockstep, results compared against a decimal model.
module tb_seq_bcd_outport;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;

  always #5 clock = ~clock;

  seq_bcd_outport_if #(.WIDTH(32)) b0 ();
  seq_bcd_outport_if #(.WIDTH(32)) b1 ();

  seq_bcd_outport #(.WIDTH(32), .BLANK_LEADING_ZERO(1'b1)) u_blank (
    .clock (clock),
    .reset (reset),
    .port  (b0)
  );

  seq_bcd_outport #(.WIDTH(32), .BLANK_LEADING_ZERO(1'b0)) u_zero (
    .clock (clock),
    .reset (reset),
    .port  (b1)
  );

  always @(negedge clock) if (b0.done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: decimal digits by plain arithmetic and a lookup table.
  function automatic logic [6:0] ref_seg(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tbl[d];
  endfunction

  function automatic logic [6:0] ref_hi(input logic [31:0] v, input bit blank);
    if (v > 32'd99) return 7'b0111111;
    if (blank && (v / 10 == 0)) return 7'b1111111;
    return ref_seg(int'(v / 10));
  endfunction

  function automatic logic [6:0] ref_lo(input logic [31:0] v);
    if (v > 32'd99) return 7'b0111111;
    return ref_seg(int'(v % 10));
  endfunction

  function automatic int ref_lat(input logic [31:0] v);
    // edges from the input change to the done sample
    return (v > 32'd99) ? 2 : 9;
  endfunction

  // Wait (bounded) for a done pulse; report edges taken and busy samples seen.
  task automatic wait_done(output int edges, output bit seen, output int busy_cnt);
    edges = 0; seen = 1'b0; busy_cnt = 0;
    while (!seen && edges < 40) begin
      @(posedge clock); #1;
      edges++;
      if (b0.busy === 1'b1) busy_cnt++;
      if (b0.done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic check_result(input logic [31:0] v);
    chk("hex_hi_blank", 32'(b0.hex_hi), 32'(ref_hi(v, 1'b1)));
    chk("hex_lo_blank", 32'(b0.hex_lo), 32'(ref_lo(v)));
    chk("hex_hi_zero",  32'(b1.hex_hi), 32'(ref_hi(v, 1'b0)));
    chk("hex_lo_zero",  32'(b1.hex_lo), 32'(ref_lo(v)));
    chk("done_zero_inst", 32'(b1.done), 32'd1);
  endtask

  task automatic expect_conv(input logic [31:0] v, input string tag);
    int  e, bc;
    bit  s;
    wait_done(e, s, bc);
    chk({tag, "_done_seen"}, 32'(s), 32'd1);
    chk({tag, "_latency"}, 32'(e), 32'(ref_lat(v)));
    chk({tag, "_busy_cycles"}, 32'(bc), 32'(ref_lat(v) - 1));
    check_result(v);
    @(posedge clock); #1;
    chk({tag, "_done_one_cycle"}, 32'(b0.done), 32'd0);
    chk({tag, "_busy_idle"}, 32'(b0.busy), 32'd0);
  endtask

  task automatic run_value(input logic [31:0] v, input string tag);
    @(negedge clock);
    b0.data_in = v;
    b1.data_in = v;
    expect_conv(v, tag);
  endtask

  initial begin
    logic [31:0] prev, v;
    int          base, e, bc;
    bit          s;

    reset = 1'b1;
    b0.data_in = '0;
    b1.data_in = '0;
    #12;
    chk("rst_busy",   32'(b0.busy),   32'd0);
    chk("rst_done",   32'(b0.done),   32'd0);
    chk("rst_hex_hi", 32'(b0.hex_hi), 32'h7F);
    chk("rst_hex_lo", 32'(b0.hex_lo), 32'h40);
    chk("rst_hex_hi_zero", 32'(b1.hex_hi), 32'h40);
    @(negedge clock);
    reset = 1'b0;

    // Reset in the middle of a conversion of 42.
    @(negedge clock);
    b0.data_in = 32'd42;
    b1.data_in = 32'd42;
    repeat (3) @(negedge clock);
    chk("midshift_busy", 32'(b0.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy",   32'(b0.busy),   32'd0);
    chk("async_rst_done",   32'(b0.done),   32'd0);
    chk("async_rst_hex_hi", 32'(b0.hex_hi), 32'h7F);
    chk("async_rst_hex_lo", 32'(b0.hex_lo), 32'h40);
    @(negedge clock);
    reset = 1'b0;
    expect_conv(32'd42, "reconv42");

    run_value(32'd5,          "v5");
    run_value(32'd42,         "v42");
    run_value(32'd99,         "v99");
    run_value(32'd100,        "v100");
    run_value(32'hFFFF_FFFF,  "vmax");

    // 77 arrives while 8 is still converting: 8 shows first, then 77.
    @(negedge clock);
    base = done_cnt;
    b0.data_in = 32'd8;
    b1.data_in = 32'd8;
    repeat (2) @(negedge clock);
    b0.data_in = 32'd77;
    b1.data_in = 32'd77;
    wait_done(e, s, bc);
    chk("v8_done_seen", 32'(s), 32'd1);
    chk("v8_latency_rest", 32'(e), 32'd7);
    check_result(32'd8);
    wait_done(e, s, bc);
    chk("v77_done_seen", 32'(s), 32'd1);
    chk("v77_latency", 32'(e), 32'd9);
    check_result(32'd77);
    repeat (12) @(negedge clock);
    chk("v8_77_done_pulses", 32'(done_cnt - base), 32'd2);

    run_value(32'd7, "v7");

    prev = 32'd7;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 9) < 2) v = $urandom;
      else v = 32'($urandom_range(0, 99));
      if (v == prev) v = v + 32'd1;
      run_value(v, "rand");
      prev = v;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
